rst_seq_gen: RTL and testbench

RST_SEQ_GEN -- requirements
Module: rst_seq_gen

---
 rtl/rst_seq_gen.sv | 133 +++++++++++++
 tb/tb_rst_seq_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Power-on / software reset sequencer: holds NUM_CH reset outputs low, then releases them one by one.
// Optional sticky reset-cause capture is built only when RST_SEQ_GEN_CAUSE_EN is defined.
module rst_seq_gen #(
    parameter int NUM_CH         = 3,
    parameter int CTR_WIDTH      = 8,
    parameter int RESET_CYCLES   = 200,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sys_reset,
    input  logic              wdt_reset,
    input  logic              cause_clear,
    output logic [NUM_CH-1:0] rst_n,
    output logic              busy,
    output logic [1:0]        reset_cause
);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_STAGGER,
        ST_RUN
    } state_t;

    localparam logic [CTR_WIDTH-1:0] RESET_LAST   = CTR_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] STAGGER_LAST = CTR_WIDTH'(STAGGER_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CTR_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [NUM_CH-1:0]     rst_n_q, rst_n_d;
    logic                  sys_q,   sys_d;
    logic                  wdt_q,   wdt_d;
    logic                  req_reg;

    assign req_reg = sys_q | wdt_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_n_d = rst_n_q;
        sys_d   = sys_reset;
        wdt_d   = wdt_reset;

        if (req_reg) begin
            // A request discards any partial release and restarts from the top.
            state_d = ST_ASSERT;
            cnt_d   = '0;
            rst_n_d = '0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    rst_n_d = '0;
                    if (cnt_q == RESET_LAST) begin
                        cnt_d      = '0;
                        rst_n_d[0] = 1'b1;
                        state_d    = (NUM_CH == 1) ? ST_RUN : ST_STAGGER;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STAGGER: begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_d      = '0;
                        // Shift the released region up by one channel.
                        rst_n_d[0] = 1'b1;
                        for (int k = 1; k < NUM_CH; k++) begin
                            rst_n_d[k] = rst_n_q[k-1];
                        end
                        if (&rst_n_d) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_n_d = '1;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    rst_n_d = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            rst_n_q <= '0;
            sys_q   <= 1'b0;
            wdt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            sys_q   <= sys_d;
            wdt_q   <= wdt_d;
        end
    end

    assign rst_n = rst_n_q;
    assign busy  = (state_q != ST_RUN);

`ifdef RST_SEQ_GEN_CAUSE_EN
    logic [1:0] cause_q, cause_d;

    // Set terms are OR-ed in after the clear, so a set wins in the same cycle.
    always_comb begin
        cause_d = (cause_q & ~{2{cause_clear}}) | {wdt_q, sys_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q <= 2'b00;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign reset_cause = cause_q;
`else
    logic unused_cause_clear;

    assign unused_cause_clear = cause_clear;
    assign reset_cause        = 2'b00;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen with NUM_CH=3, RESET_CYCLES=10, STAGGER_CYCLES=4.
// Cause expectations follow RST_SEQ_GEN_CAUSE_EN when the bench is built with it.
module tb_rst_seq_gen;

    localparam int NUM_CH  = 3;
    localparam int RC      = 10;
    localparam int SC      = 4;
`ifdef RST_SEQ_GEN_CAUSE_EN
    localparam bit CAUSE_ON = 1'b1;
`else
    localparam bit CAUSE_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sys_reset;
    logic              wdt_reset;
    logic              cause_clear;
    logic [NUM_CH-1:0] rst_n;
    logic              busy;
    logic [1:0]        reset_cause;

    int n_checks = 0;
    int n_fail   = 0;

    rst_seq_gen #(
        .NUM_CH        (NUM_CH),
        .CTR_WIDTH     (8),
        .RESET_CYCLES  (RC),
        .STAGGER_CYCLES(SC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sys_reset  (sys_reset),
        .wdt_reset  (wdt_reset),
        .cause_clear(cause_clear),
        .rst_n      (rst_n),
        .busy       (busy),
        .reset_cause(reset_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Channel k is released once s >= RC + k*SC, s = edges counted from the first non-reset edge.
    function automatic logic [NUM_CH-1:0] exp_rst(input int s);
        logic [NUM_CH-1:0] r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (s >= RC + k * SC) r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_cause(input logic [1:0] c);
        return CAUSE_ON ? c : 2'b00;
    endfunction

    task automatic run_seq(input string tag, input int upto);
        for (int s = 1; s <= upto; s++) begin
            cyc();
            check($sformatf("%s_rst_s%0d", tag, s), 32'(rst_n), 32'(exp_rst(s)));
            check($sformatf("%s_busy_s%0d", tag, s), 32'(busy), 32'(exp_rst(s) != '1));
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        sys_reset   = 1'b0;
        wdt_reset   = 1'b0;
        cause_clear = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check("por_rst_n", 32'(rst_n), 32'h0);
        check("por_busy", 32'(busy), 32'h1);
        check("por_cause", 32'(reset_cause), 32'h0);

        // Basic sequence: 001 @10, 011 @14, 111 @18, busy drops @18.
        @(negedge clk);
        reset_n = 1'b1;
        run_seq("boot", 20);

        // sys_reset pulse in RUN, sampled at edge N.
        sys_reset = 1'b1;
        cyc();
        check("sys_edgeN_rst", 32'(rst_n), 32'h7);
        sys_reset = 1'b0;
        cyc();
        check("sys_edgeN1_rst", 32'(rst_n), 32'h0);
        check("sys_edgeN1_busy", 32'(busy), 32'h1);
        check("sys_cause", 32'(reset_cause), 32'(exp_cause(2'b01)));
        run_seq("sys", 15);

        // wdt_reset pulse while rst_n=011.
        check("stag_pre_rst", 32'(rst_n), 32'h3);
        wdt_reset = 1'b1;
        cyc();
        check("wdt_edgeM_rst", 32'(rst_n), 32'h3);
        wdt_reset = 1'b0;
        cyc();
        check("wdt_edgeM1_rst", 32'(rst_n), 32'h0);
        check("wdt_edgeM1_busy", 32'(busy), 32'h1);
        check("wdt_cause", 32'(reset_cause), 32'(exp_cause(2'b11)));
        run_seq("wdt", 18);

        // cause_clear alone clears the cause and does not disturb the channels.
        cause_clear = 1'b1;
        cyc();
        cause_clear = 1'b0;
        check("clr_cause", 32'(reset_cause), 32'h0);
        check("clr_rst", 32'(rst_n), 32'h7);

        // Cause = 01, then clear coincides with wdt_reg high: set wins -> 10.
        sys_reset = 1'b1;
        cyc();
        sys_reset = 1'b0;
        cyc();
        check("c01_cause", 32'(reset_cause), 32'(exp_cause(2'b01)));
        wdt_reset = 1'b1;
        cyc();
        wdt_reset   = 1'b0;
        cause_clear = 1'b1;
        cyc();
        cause_clear = 1'b0;
        check("setwin_cause", 32'(reset_cause), 32'(exp_cause(2'b10)));
        check("setwin_rst", 32'(rst_n), 32'h0);
        run_seq("setwin", 18);

        // sys_reset held for 50 cycles: channels held, counter frozen.
        sys_reset = 1'b1;
        cyc();
        for (int i = 1; i < 50; i++) begin
            cyc();
            check($sformatf("hold_rst_%0d", i), 32'(rst_n), 32'h0);
        end
        sys_reset = 1'b0;
        cyc();
        check("hold_tail_rst", 32'(rst_n), 32'h0);
        run_seq("hold", 15);

        // Async reset_n pulse mid-STAGGER between clock edges.
        check("async_pre_rst", 32'(rst_n), 32'h3);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst", 32'(rst_n), 32'h0);
        check("async_busy", 32'(busy), 32'h1);
        check("async_cause", 32'(reset_cause), 32'h0);
        #1;
        reset_n = 1'b1;
        run_seq("reboot", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
